alarm_ring_controller: RTL and testbench

Sequences the alarm sounder for the alarm clock. It watches the current time and the stored alarm time, both as 4-digit BCD HH:MM. On a match it rings, then handles snooze, stop, disable and ring timeout. It sits beside the key/display FSM and drives the speaker-enable and status LEDs; it never writes either time register.

---
 rtl/alarm_pkg.sv | 25 ++
 rtl/alarm_ring_controller_sec_counter.sv | 31 +++
 rtl/alarm_ring_controller.sv | 125 ++++++++++++
 tb/tb_alarm_ring_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock blocks: state encoding, time word
// layout and the key FSM's idle key code.
package alarm_pkg;

    // Width of one BCD digit and of the packed {H1,H0,M1,M0} time word
    localparam int BCD_W  = 4;
    localparam int TIME_W = 4 * BCD_W;

    // Key code the key/display FSM uses for "no key pressed"
    localparam logic [BCD_W-1:0] NOKEY = 4'hF;

    // Ring sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

    // Plain bitwise compare; out-of-range BCD digits are deliberately not screened
    function automatic logic time_equal(input logic [TIME_W-1:0] a,
                                        input logic [TIME_W-1:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/alarm_ring_controller_sec_counter.sv
// Counts one_second pulses while enabled; done fires combinationally on the
// pulse that reaches TERMINAL so the owner can leave its state on that edge.
module sec_counter #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 60
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic one_second,
    output logic done
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] count_reg;

    // Pulse counter; held at zero whenever the owning state is not active
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (one_second) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign done = one_second && !clear && (count_reg == LAST);

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm sounder sequencer: detects the rising edge of a time match, rings,
// and handles snooze, stop, disable and ring timeout.
module alarm_ring_controller
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SECS  = 300,
    parameter int MAX_SNOOZES  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              one_second,
    input  logic [TIME_W-1:0] current_time,
    input  logic [TIME_W-1:0] alarm_time,
    input  logic              alarm_enable,
    input  logic              stop_button,
    input  logic              snooze_button,
    output logic              sound_alarm,
    output logic              snooze_active,
    output logic              alarm_missed,
    output logic [2:0]        snoozes_left
);

    localparam logic [2:0] SNOOZE_LOAD = 3'(MAX_SNOOZES);

    alarm_state_t state_reg, state_next;
    logic         match, match_d_reg, trigger;
    logic [2:0]   snoozes_left_reg, snoozes_left_next;
    logic         alarm_missed_reg, alarm_missed_next;
    logic         ring_done, snooze_done;
    logic         ring_clear, snooze_clear;

    // Only the rising edge of a match rings, so a stopped alarm stays quiet
    // for the rest of the minute and enabling during a match does nothing.
    assign match   = time_equal(current_time, alarm_time);
    assign trigger = match && !match_d_reg && alarm_enable;

    // Counters run only in their own state; leaving the state zeroes them so
    // every entry starts a fresh count.
    assign ring_clear   = (state_reg != RINGING);
    assign snooze_clear = (state_reg != SNOOZE);

    sec_counter #(.WIDTH(8), .TERMINAL(RING_TIMEOUT)) u_ring_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (ring_clear),
        .one_second (one_second),
        .done       (ring_done)
    );

    sec_counter #(.WIDTH(10), .TERMINAL(SNOOZE_SECS)) u_snooze_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (snooze_clear),
        .one_second (one_second),
        .done       (snooze_done)
    );

    // State, match history, snooze budget and missed flag registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg        <= IDLE;
            match_d_reg      <= 1'b0;
            snoozes_left_reg <= SNOOZE_LOAD;
            alarm_missed_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            match_d_reg      <= match;
            snoozes_left_reg <= snoozes_left_next;
            alarm_missed_reg <= alarm_missed_next;
        end
    end

    // Next-state logic; buttons outrank timeouts so a press on the timeout
    // pulse is honoured instead of flagging a missed alarm.
    always_comb begin
        state_next        = state_reg;
        snoozes_left_next = snoozes_left_reg;
        alarm_missed_next = alarm_missed_reg;

        if (stop_button || trigger) begin
            alarm_missed_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (trigger) begin
                    state_next        = RINGING;
                    snoozes_left_next = SNOOZE_LOAD;
                end
            end
            RINGING: begin
                if (!alarm_enable) begin
                    state_next = IDLE;
                end else if (stop_button) begin
                    state_next = IDLE;
                end else if (snooze_button && (snoozes_left_reg != 3'd0)) begin
                    state_next        = SNOOZE;
                    snoozes_left_next = snoozes_left_reg - 3'd1;
                end else if (ring_done) begin
                    state_next        = IDLE;
                    alarm_missed_next = 1'b1;
                end
            end
            SNOOZE: begin
                if (!alarm_enable) begin
                    state_next = IDLE;
                end else if (stop_button) begin
                    state_next = IDLE;
                end else if (snooze_done) begin
                    state_next = RINGING;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sound_alarm   = (state_reg == RINGING);
    assign snooze_active = (state_reg == SNOOZE);
    assign alarm_missed  = alarm_missed_reg;
    assign snoozes_left  = snoozes_left_reg;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed bench for alarm_ring_controller with RING_TIMEOUT=5,
// SNOOZE_SECS=3, MAX_SNOOZES=2.
module tb_alarm_ring_controller;

    logic        clock;
    logic        reset;
    logic        one_second;
    logic [15:0] current_time;
    logic [15:0] alarm_time;
    logic        alarm_enable;
    logic        stop_button;
    logic        snooze_button;
    logic        sound_alarm;
    logic        snooze_active;
    logic        alarm_missed;
    logic [2:0]  snoozes_left;

    int checks_cnt;
    int errors_cnt;

    alarm_ring_controller #(
        .RING_TIMEOUT (5),
        .SNOOZE_SECS  (3),
        .MAX_SNOOZES  (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .one_second    (one_second),
        .current_time  (current_time),
        .alarm_time    (alarm_time),
        .alarm_enable  (alarm_enable),
        .stop_button   (stop_button),
        .snooze_button (snooze_button),
        .sound_alarm   (sound_alarm),
        .snooze_active (snooze_active),
        .alarm_missed  (alarm_missed),
        .snoozes_left  (snoozes_left)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against the hand-computed expectation
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One-cycle one_second pulse followed by one quiet cycle
    task automatic pulse();
        one_second = 1'b1;
        tick();
        one_second = 1'b0;
        tick();
    endtask

    // Create a fresh rising edge of match: move off the alarm minute and back
    task automatic retrigger();
        current_time = 16'h0731;
        tick();
        current_time = 16'h0730;
        tick();
    endtask

    // Single-cycle snooze press
    task automatic press_snooze();
        snooze_button = 1'b1;
        tick();
        snooze_button = 1'b0;
    endtask

    // Single-cycle stop press
    task automatic press_stop();
        stop_button = 1'b1;
        tick();
        stop_button = 1'b0;
    endtask

    initial begin
        checks_cnt    = 0;
        errors_cnt    = 0;
        reset         = 1'b0;
        one_second    = 1'b0;
        current_time  = 16'h0000;
        alarm_time    = 16'h0730;
        alarm_enable  = 1'b1;
        stop_button   = 1'b0;
        snooze_button = 1'b0;
        tick();
        tick();
        check_val("rst_sound",  sound_alarm,   1'b0);
        check_val("rst_snooze", snooze_active, 1'b0);
        check_val("rst_missed", alarm_missed,  1'b0);
        check_val("rst_left",   snoozes_left,  3'd2);
        reset = 1'b1;

        // Trigger and stop
        current_time = 16'h0729;
        tick();
        check_val("pre_match_sound", sound_alarm, 1'b0);
        current_time = 16'h0730;
        tick();
        check_val("trig_sound", sound_alarm, 1'b1);
        check_val("trig_left", snoozes_left, 3'd2);
        press_stop();
        check_val("stop_sound", sound_alarm, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("hold_no_rering", sound_alarm, 1'b0);
        end

        // Timeout after 5 pulses
        retrigger();
        check_val("to_trig_sound", sound_alarm, 1'b1);
        for (int i = 0; i < 4; i++) pulse();
        check_val("to_4_sound", sound_alarm, 1'b1);
        check_val("to_4_missed", alarm_missed, 1'b0);
        one_second = 1'b1;
        tick();
        one_second = 1'b0;
        check_val("to_5_sound", sound_alarm, 1'b0);
        check_val("to_5_missed", alarm_missed, 1'b1);
        tick();
        tick();
        check_val("missed_sticky", alarm_missed, 1'b1);
        press_stop();
        check_val("missed_cleared", alarm_missed, 1'b0);

        // Snooze limit
        retrigger();
        check_val("sl_trig_sound", sound_alarm, 1'b1);
        press_snooze();
        check_val("sl1_snooze", snooze_active, 1'b1);
        check_val("sl1_sound", sound_alarm, 1'b0);
        check_val("sl1_left", snoozes_left, 3'd1);
        pulse();
        pulse();
        check_val("sl1_2p_snooze", snooze_active, 1'b1);
        one_second = 1'b1;
        tick();
        one_second = 1'b0;
        check_val("sl1_rering", sound_alarm, 1'b1);
        check_val("sl1_rering_snz", snooze_active, 1'b0);
        press_snooze();
        check_val("sl2_snooze", snooze_active, 1'b1);
        check_val("sl2_left", snoozes_left, 3'd0);
        for (int i = 0; i < 3; i++) pulse();
        check_val("sl2_rering", sound_alarm, 1'b1);
        press_snooze();
        check_val("sl3_ignored_sound", sound_alarm, 1'b1);
        check_val("sl3_ignored_snz", snooze_active, 1'b0);
        check_val("sl3_left", snoozes_left, 3'd0);
        press_stop();
        check_val("sl_stop_sound", sound_alarm, 1'b0);

        // Stop and timeout on the same cycle
        retrigger();
        for (int i = 0; i < 4; i++) pulse();
        check_val("col_4_sound", sound_alarm, 1'b1);
        one_second  = 1'b1;
        stop_button = 1'b1;
        tick();
        one_second  = 1'b0;
        stop_button = 1'b0;
        check_val("col_sound", sound_alarm, 1'b0);
        check_val("col_missed", alarm_missed, 1'b0);

        // Disable during snooze, then re-enable inside the matching minute
        retrigger();
        press_snooze();
        check_val("dis_snooze", snooze_active, 1'b1);
        alarm_enable = 1'b0;
        tick();
        check_val("dis_snooze_off", snooze_active, 1'b0);
        check_val("dis_sound_off", sound_alarm, 1'b0);
        alarm_enable = 1'b1;
        tick();
        tick();
        check_val("reen_no_ring", sound_alarm, 1'b0);

        // Reset mid-ring after one snooze has been used
        retrigger();
        press_snooze();
        for (int i = 0; i < 3; i++) pulse();
        check_val("mr_ringing", sound_alarm, 1'b1);
        check_val("mr_left", snoozes_left, 3'd1);
        current_time = 16'h0731;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_val("mr_sound", sound_alarm, 1'b0);
        check_val("mr_snooze", snooze_active, 1'b0);
        check_val("mr_missed", alarm_missed, 1'b0);
        check_val("mr_left_reload", snoozes_left, 3'd2);
        tick();
        check_val("mr_after_sound", sound_alarm, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
